// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write-back arbiter: producer indices,
// producer count, write-record layout and the round-robin pick helper.
package register_write_arbiter_pkg;

   localparam int NUM_SRC  = 4;
   localparam int SRC_MISC = 0;
   localparam int SRC_ALU  = 1;
   localparam int SRC_MEM  = 2;
   localparam int SRC_FPU  = 3;

   // Write record is packed as {float, addr, data}, data in the low bits.
   function automatic int rec_w(input int data_w, input int addr_w);
      return data_w + addr_w + 1;
   endfunction

   // Returns {found, index} of the first full buffer at or above ptr, wrapping.
   function automatic logic [2:0] rr_pick(input logic [3:0] full, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (full[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

endpackage

// File: rtl/register_write_arbiter_wb_src_buffer.sv
// One-entry producer buffer: loads on valid&&ready, empties when granted,
// and can be emptied and refilled on the same edge.
module wb_src_buffer #(
   parameter int W = 38
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         valid_i,
   input  logic         grant_i,
   input  logic [W-1:0] payload_i,
   output logic         ready_o,
   output logic         full_o,
   output logic         full_next_o,
   output logic [W-1:0] payload_o
);

   logic         full_q, full_d;
   logic [W-1:0] payload_q;
   logic         load;

   // Handshake: transfer on an edge where valid_i && ready_o; ready_o never
   // looks at valid_i, and a granted buffer is ready so it can refill at once.
   assign ready_o = !full_q || grant_i;
   assign load    = valid_i && ready_o;

   always_comb begin
      full_d = full_q;
      if (load)         full_d = 1'b1;
      else if (grant_i) full_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q    <= 1'b0;
         payload_q <= '0;
      end else begin
         full_q <= full_d;
         if (load) payload_q <= payload_i;
      end
   end

   assign full_o      = full_q;
   assign full_next_o = full_d;
   assign payload_o   = payload_q;

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among misc/alu/mem/fpu.
// Optional REG_WB_ZERO_DISCARD_EN suppresses the write strobe for int r0 writes.
module register_write_arbiter
   import register_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_SRC    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  misc_valid,
   input  logic                  alu_valid,
   input  logic                  mem_valid,
   input  logic                  fpu_valid,
   output logic                  misc_ready,
   output logic                  alu_ready,
   output logic                  mem_ready,
   output logic                  fpu_ready,
   input  logic [ADDR_WIDTH-1:0] misc_addr,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [ADDR_WIDTH-1:0] fpu_addr,
   input  logic [DATA_WIDTH-1:0] misc_data,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] fpu_data,
   input  logic                  misc_float,
   input  logic                  alu_float,
   input  logic                  mem_float,
   input  logic                  fpu_float,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  write_float,
   output logic                  busy
);

   localparam int REC_W = rec_w(DATA_WIDTH, ADDR_WIDTH);

   logic [NUM_SRC-1:0] valid, ready, full, full_next, grant;
   logic [REC_W-1:0]   rec_in [NUM_SRC];
   logic [REC_W-1:0]   rec_q  [NUM_SRC];

   logic [1:0]            rr_ptr_q;
   logic [2:0]            pick;
   logic                  grant_any;
   logic [1:0]            grant_idx;
   logic [REC_W-1:0]      rec_sel;
   logic                  sel_float;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  issue;

   logic                  write_enable_q, write_float_q, busy_q;
   logic [ADDR_WIDTH-1:0] write_addr_q;
   logic [DATA_WIDTH-1:0] write_data_q;

   assign valid = {fpu_valid, mem_valid, alu_valid, misc_valid};
   assign {fpu_ready, mem_ready, alu_ready, misc_ready} = ready;

   assign rec_in[SRC_MISC] = {misc_float, misc_addr, misc_data};
   assign rec_in[SRC_ALU]  = {alu_float,  alu_addr,  alu_data};
   assign rec_in[SRC_MEM]  = {mem_float,  mem_addr,  mem_data};
   assign rec_in[SRC_FPU]  = {fpu_float,  fpu_addr,  fpu_data};

   // Grant is a function of buffer flags, pointer and hold only, never of valid.
   assign pick      = rr_pick(full, rr_ptr_q);
   assign grant_idx = pick[1:0];

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      if (!hold && pick[2]) begin
         grant_any        = 1'b1;
         grant[grant_idx] = 1'b1;
      end
   end

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_buf
      wb_src_buffer #(.W(REC_W)) u_buf (
         .clk_i       (clk),
         .rst_ni      (reset),
         .valid_i     (valid[s]),
         .grant_i     (grant[s]),
         .payload_i   (rec_in[s]),
         .ready_o     (ready[s]),
         .full_o      (full[s]),
         .full_next_o (full_next[s]),
         .payload_o   (rec_q[s])
      );
   end

   assign rec_sel   = rec_q[grant_idx];
   assign sel_float = rec_sel[REC_W-1];
   assign sel_addr  = rec_sel[DATA_WIDTH +: ADDR_WIDTH];
   assign sel_data  = rec_sel[DATA_WIDTH-1:0];

`ifdef REG_WB_ZERO_DISCARD_EN
   // Int r0 is hard-wired: the slot still retires, but nothing is written.
   assign issue = grant_any && !(!sel_float && (sel_addr == '0));
`else
   assign issue = grant_any;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q       <= 2'd0;
         write_enable_q <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_float_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         if (grant_any) rr_ptr_q <= grant_idx + 2'd1;
         write_enable_q <= issue;
         if (issue) begin
            write_addr_q  <= sel_addr;
            write_data_q  <= sel_data;
            write_float_q <= sel_float;
         end
         busy_q <= |full_next;
      end
   end

   assign write_enable = write_enable_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign write_float  = write_float_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter; expectations are hand-computed.
// Build with REG_WB_ZERO_DISCARD_EN to exercise the int r0 discard path.
module tb_register_write_arbiter;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        misc_valid, alu_valid, mem_valid, fpu_valid;
   logic        misc_ready, alu_ready, mem_ready, fpu_ready;
   logic [4:0]  misc_addr, alu_addr, mem_addr, fpu_addr;
   logic [31:0] misc_data, alu_data, mem_data, fpu_data;
   logic        misc_float, alu_float, mem_float, fpu_float;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        write_float;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   register_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_SRC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .hold         (hold),
      .misc_valid   (misc_valid),
      .alu_valid    (alu_valid),
      .mem_valid    (mem_valid),
      .fpu_valid    (fpu_valid),
      .misc_ready   (misc_ready),
      .alu_ready    (alu_ready),
      .mem_ready    (mem_ready),
      .fpu_ready    (fpu_ready),
      .misc_addr    (misc_addr),
      .alu_addr     (alu_addr),
      .mem_addr     (mem_addr),
      .fpu_addr     (fpu_addr),
      .misc_data    (misc_data),
      .alu_data     (alu_data),
      .mem_data     (mem_data),
      .fpu_data     (fpu_data),
      .misc_float   (misc_float),
      .alu_float    (alu_float),
      .mem_float    (mem_float),
      .fpu_float    (fpu_float),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .write_float  (write_float),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      hold       = 1'b0;
      misc_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0;
      misc_addr  = '0;   alu_addr  = '0;   mem_addr  = '0;   fpu_addr  = '0;
      misc_data  = '0;   alu_data  = '0;   mem_data  = '0;   fpu_data  = '0;
      misc_float = 1'b0; alu_float = 1'b0; mem_float = 1'b0; fpu_float = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [4:0] a,
                              input logic [31:0] d, input logic f);
      chk({tag, "_we"},    write_enable, 1'b1);
      chk({tag, "_addr"},  write_addr,   a);
      chk({tag, "_data"},  write_data,   d);
      chk({tag, "_float"}, write_float,  f);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   logic m_xfer, f_xfer;
   int   m_cnt, f_cnt;
   logic exp_we_r0;

   initial begin
      idle_inputs();
      do_reset();

      // Reset state
      chk("rst_we", write_enable, 1'b0);
      chk("rst_addr", write_addr, 5'd0);
      chk("rst_data", write_data, 32'd0);
      chk("rst_float", write_float, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", {misc_ready, alu_ready, mem_ready, fpu_ready}, 4'b1111);

      // Single alu transfer
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h12345678; alu_float = 1'b0;
      step();
      alu_valid = 1'b0;
      chk("single_busy_full", busy, 1'b1);
      chk("single_we_pre", write_enable, 1'b0);
      chk("single_alu_ready_granted", alu_ready, 1'b1);
      step();
      check_write("single", 5'd7, 32'h12345678, 1'b0);
      chk("single_busy_drained", busy, 1'b0);
      step();
      chk("single_we_off", write_enable, 1'b0);
      chk("single_addr_hold", write_addr, 5'd7);

      // All four valid on one edge, pointer back at 0
      do_reset();
      misc_valid = 1'b1; misc_addr = 5'd1; misc_data = 32'h10;
      alu_valid  = 1'b1; alu_addr  = 5'd2; alu_data  = 32'h11;
      mem_valid  = 1'b1; mem_addr  = 5'd3; mem_data  = 32'h12;
      fpu_valid  = 1'b1; fpu_addr  = 5'd4; fpu_data  = 32'h13;
      step();
      idle_inputs();
      chk("all4_ready0", {misc_ready, alu_ready, mem_ready, fpu_ready}, 4'b1000);
      chk("all4_busy0", busy, 1'b1);
      step();
      check_write("all4_misc", 5'd1, 32'h10, 1'b0);
      chk("all4_ready1", {misc_ready, alu_ready, mem_ready, fpu_ready}, 4'b1100);
      step();
      check_write("all4_alu", 5'd2, 32'h11, 1'b0);
      chk("all4_ready2", {misc_ready, alu_ready, mem_ready, fpu_ready}, 4'b1110);
      step();
      check_write("all4_mem", 5'd3, 32'h12, 1'b0);
      chk("all4_busy3", busy, 1'b1);
      step();
      check_write("all4_fpu", 5'd4, 32'h13, 1'b0);
      chk("all4_busy4", busy, 1'b0);
      step();
      chk("all4_we_off", write_enable, 1'b0);

      // mem and fpu continuously valid: writes alternate mem/fpu
      m_cnt = 0; f_cnt = 0;
      mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h20;
      fpu_valid = 1'b1; fpu_addr = 5'd6; fpu_data = 32'h30; fpu_float = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         m_xfer = mem_valid && mem_ready;
         f_xfer = fpu_valid && fpu_ready;
         step();
         if (m_xfer) begin m_cnt++; mem_data = 32'h20 + 32'(m_cnt); end
         if (f_xfer) begin f_cnt++; fpu_data = 32'h30 + 32'(f_cnt); end
         case (e)
            2: check_write("rr_w1_mem", 5'd5, 32'h20, 1'b0);
            3: check_write("rr_w2_fpu", 5'd6, 32'h30, 1'b1);
            4: check_write("rr_w3_mem", 5'd5, 32'h21, 1'b0);
            5: check_write("rr_w4_fpu", 5'd6, 32'h31, 1'b1);
            default: chk("rr_w0_none", write_enable, 1'b0);
         endcase
      end
      idle_inputs();
      step();
      check_write("rr_w5_mem", 5'd5, 32'h22, 1'b0);
      step();
      check_write("rr_w6_fpu", 5'd6, 32'h32, 1'b1);
      chk("rr_busy_end", busy, 1'b0);

      // hold with misc and fpu buffered
      hold = 1'b1;
      misc_valid = 1'b1; misc_addr = 5'd8; misc_data = 32'h40; misc_float = 1'b0;
      fpu_valid  = 1'b1; fpu_addr  = 5'd9; fpu_data  = 32'h41; fpu_float  = 1'b1;
      step();
      misc_valid = 1'b0; fpu_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("hold_we", write_enable, 1'b0);
         chk("hold_ready", {misc_ready, fpu_ready}, 2'b00);
         chk("hold_busy", busy, 1'b1);
         if (c < 2) step();
      end
      hold = 1'b0;
      #1;
      chk("hold_release_ready", {misc_ready, fpu_ready}, 2'b10);
      step();
      check_write("hold_misc", 5'd8, 32'h40, 1'b0);
      step();
      check_write("hold_fpu", 5'd9, 32'h41, 1'b1);
      step();
      chk("hold_we_off", write_enable, 1'b0);
      chk("hold_busy_off", busy, 1'b0);

      // Async reset with three full buffers
      idle_inputs();
      misc_valid = 1'b1; misc_addr = 5'd10; misc_data = 32'h50;
      alu_valid  = 1'b1; alu_addr  = 5'd11; alu_data  = 32'h51;
      mem_valid  = 1'b1; mem_addr  = 5'd12; mem_data  = 32'h52;
      step();
      idle_inputs();
      step();
      check_write("arst_pre", 5'd10, 32'h50, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("arst_we", write_enable, 1'b0);
      chk("arst_addr", write_addr, 5'd0);
      chk("arst_data", write_data, 32'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_ready", {misc_ready, alu_ready, mem_ready, fpu_ready}, 4'b1111);
      step();
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("arst_no_stale_we", write_enable, 1'b0);
         chk("arst_no_stale_busy", busy, 1'b0);
      end

      // Int and float writes to r0
`ifdef REG_WB_ZERO_DISCARD_EN
      exp_we_r0 = 1'b0;
`else
      exp_we_r0 = 1'b1;
`endif
      misc_valid = 1'b1; misc_addr = 5'd0; misc_data = 32'hFFFFFFFF; misc_float = 1'b0;
      step();
      misc_valid = 1'b0;
      step();
      chk("r0_int_we", write_enable, exp_we_r0);
      chk("r0_int_ready", misc_ready, 1'b1);
      chk("r0_int_busy", busy, 1'b0);
      misc_valid = 1'b1; misc_addr = 5'd0; misc_data = 32'h3F800000; misc_float = 1'b1;
      step();
      misc_valid = 1'b0;
      step();
      check_write("r0_float", 5'd0, 32'h3F800000, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
Shares the single register-file write port among four result producers: misc, alu, mem and fpu. Each producer has a one-entry input buffer with a valid/ready handshake. A round-robin arbiter drains the buffers and drives one registered write per cycle (enable, addr, data, float) into the register manager's write side. Producers never drop a result, and no producer is starved.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, width of register address
NUM_SRC, 4, number of producers; fixed at 4 (index 0 misc, 1 alu, 2 mem, 3 fpu); other values unsupported

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
hold  input  1  freeze arbitration; buffers keep contents, no writes issued
misc_valid, alu_valid, mem_valid, fpu_valid  input  1 each  producer has a result
misc_ready, alu_ready, mem_ready, fpu_ready  output  1 each  buffer can take the result this cycle
misc_addr, alu_addr, mem_addr, fpu_addr  input  ADDR_WIDTH each  destination register
misc_data, alu_data, mem_data, fpu_data  input  DATA_WIDTH each  result value
misc_float, alu_float, mem_float, fpu_float  input  1 each  1 = float file, 0 = int file
write_enable  output  1  registered write strobe to register manager
write_addr  output  ADDR_WIDTH  registered destination
write_data  output  DATA_WIDTH  registered value
write_float  output  1  registered file select
busy  output  1  OR of all buffer-full flags, registered

Behaviour:
- Reset (reset=0, async): all buffers empty; rr_ptr=0; write_enable=0, write_addr=0, write_data=0, write_float=0; busy=0.
- Handshake: a transfer occurs on a clock edge where valid_i && ready_i. After a transfer the buffer captures {addr, data, float} and full_i=1. Producers hold valid and payload stable until ready. ready_i does not depend on valid_i.
- ready_i = !full_i || grant_i, where grant_i depends only on buffer flags, rr_ptr and hold. This allows full throughput: a buffer may be freed and refilled on the same edge.
- Arbitration (combinational, per cycle):
  - If hold=1: no grant.
  - Otherwise: grant the first full buffer found scanning from rr_ptr upward, modulo 4.
  - At most one grant per cycle.
- rr_ptr update: on a grant to index g, rr_ptr <= (g+1) mod 4. With no grant, rr_ptr is unchanged.
- Output stage: on the edge after a grant, write_enable=1 and write_addr/data/float take the granted buffer contents. Otherwise write_enable=0, and addr/data/float hold their last values.
- Latency: transfer at edge N -> buffer full -> earliest write_enable at edge N+1, visible in cycle N+1..N+2. Minimum 1 cycle from acceptance to write, plus wait time behind other producers.
- Worst-case wait with all four buffers full: 3 grants.
- Ordering: results from one producer retire in acceptance order. Results from different producers have no ordering guarantee; the issuing pipeline guarantees no WAW between producers.
- Simultaneous events:
  - Grant and refill of the same buffer on one edge: the new payload is stored, full stays 1.
  - hold asserted while buffers are full: buffers keep contents, ready_i=0 for full buffers.
  - All four producers valid with all buffers empty: all four accepted on one edge.
- Reset mid-operation: buffered results are discarded and no write is issued. The pipeline flush accompanying reset makes this acceptable.
- busy is registered as the OR of next-state full flags.

Optional Feature:
Macro REG_WB_ZERO_DISCARD_EN.
- Defined: an int write (float=0) to address 0 is still accepted and granted normally and frees its buffer and advances rr_ptr, but write_enable stays 0 for that slot. The int r0 therefore stays constant. Float address 0 writes are unaffected.
- Undefined: all granted writes, including int r0, assert write_enable.

Decomposition:
- Shared package: source-index constants (SRC_MISC=0, SRC_ALU=1, SRC_MEM=2, SRC_FPU=3), NUM_SRC, and the write-record layout {float, addr, data}.
- One sub-module, wb_src_buffer: the single-entry buffer with full flag, load on valid&&ready, clear on grant. It is instantiated four times.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset, then single source: alu_valid=1, addr=7, data=0x12345678, float=0 for one transfer -> next cycle write_enable=1, write_addr=7, write_data=0x12345678, write_float=0; then write_enable=0, busy=0.
- All four valid on one edge with data 0x10/0x11/0x12/0x13 and rr_ptr=0 -> writes issue on four consecutive cycles in order misc, alu, mem, fpu. During that time ready=0 for the ungranted full buffers.
- Round-robin fairness: mem and fpu continuously valid -> grants alternate mem, fpu, mem, fpu. Neither source waits more than one extra cycle.
- hold: fill misc and fpu buffers, raise hold for 3 cycles -> write_enable=0, misc_ready=fpu_ready=0, busy=1. On release -> misc then fpu written on the next two cycles.
- Async reset with three full buffers, reset asserted mid-cycle -> outputs immediately 0, busy=0. After release, no stale write appears.
- REG_WB_ZERO_DISCARD_EN defined: misc writes int r0 = 0xFFFFFFFF -> misc_ready returns to 1 and write_enable stays 0. Float r0 = 0x3F800000 -> write_enable=1, write_float=1. With the macro undefined, the int r0 case gives write_enable=1.
